// File: rtl/mem_bus_master_pkg.sv
// Shared types and helpers for the memory "chip" bus initiator.
// The request struct uses the default 16-bit address/data widths.
package mem_bus_master_pkg;

    localparam int MEM_ADDR_W = 16;
    localparam int MEM_DATA_W = 16;

    // Active-low strobe encodings seen by the memory chips
    typedef enum logic {
        MEM_WR    = 1'b0,
        MEM_NO_WR = 1'b1
    } wr_cond_code_t;

    typedef enum logic {
        MEM_RD    = 1'b0,
        MEM_NO_RD = 1'b1
    } rd_cond_code_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WR_SETUP  = 2'd1,
        WR_STROBE = 2'd2,
        RD_ACCESS = 2'd3
    } mem_master_state_t;

    typedef struct packed {
        logic                  write;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
    } mem_req_t;

    // Saturating increment for the 16-bit transaction counters
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        logic [15:0] result;
        if (value == 16'hFFFF) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/mem_bus_master_if.sv
// Request/response handshake channels between a client and mem_bus_master.
// master = the client issuing requests, slave = mem_bus_master.
interface mem_bus_master_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/mem_bus_master_fifo.sv
// Request queue: power-of-two depth, synchronous active-low reset.
// Pointers carry one extra wrap bit to tell full from empty.
module mem_bus_master_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 33
) (
    input  logic             clock,
    input  logic             reset_L,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                       (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign rdata     = mem_r[rd_ptr_r[AW-1:0]];

    // Pointer update; a push while full is dropped
    always_ff @(posedge clock) begin
        if (!reset_L) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Storage write; contents need no reset since empty masks them
    always_ff @(posedge clock) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wdata;
        end
    end
endmodule

// File: rtl/mem_bus_master.sv
// Initiator for the memory "chip" bus: queues requests, sequences
// address/we_L/re_L and the shared tristate data bus, returns read data.
// Optional macro MEM_BUS_MASTER_STATS_EN enables rd_count/wr_count.
module mem_bus_master
    import mem_bus_master_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int WAIT_STATES = 0,
    parameter int QDEPTH      = 2
) (
    input  logic               clock,
    input  logic               reset_L,
    mem_bus_master_if.slave    bus,
    output logic [ADDR_W-1:0]  address,
    output wr_cond_code_t      we_L,
    output rd_cond_code_t      re_L,
    inout  wire  [DATA_W-1:0]  data,
    output logic [15:0]        rd_count,
    output logic [15:0]        wr_count
);
    localparam int          REQ_W         = 1 + ADDR_W + DATA_W;
    localparam logic [2:0]  WAIT_CNT_INIT = 3'(WAIT_STATES);

    mem_master_state_t state_r;
    mem_master_state_t state_s;
    logic [REQ_W-1:0]  head_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic              pop_s;
    logic              capture_s;
    logic              rsp_take_s;
    logic              head_write_s;
    logic [ADDR_W-1:0] head_addr_s;
    logic [DATA_W-1:0] head_wdata_s;
    logic [2:0]        wait_cnt_r;
    logic [ADDR_W-1:0] address_r;
    logic [DATA_W-1:0] wdata_r;
    logic              drive_r;
    wr_cond_code_t     we_r;
    rd_cond_code_t     re_r;
    logic              rsp_valid_r;
    logic [DATA_W-1:0] rsp_rdata_r;

    mem_bus_master_fifo #(
        .DEPTH (QDEPTH),
        .WIDTH (REQ_W)
    ) u_fifo (
        .clock   (clock),
        .reset_L (reset_L),
        .push    (bus.req_valid),
        .wdata   ({bus.req_write, bus.req_addr, bus.req_wdata}),
        .pop     (pop_s),
        .rdata   (head_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    assign head_write_s = head_s[REQ_W-1];
    assign head_addr_s  = head_s[ADDR_W+DATA_W-1:DATA_W];
    assign head_wdata_s = head_s[DATA_W-1:0];
    assign rsp_take_s   = rsp_valid_r && bus.rsp_ready;

    assign bus.req_ready = !fifo_full_s;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_rdata = rsp_rdata_r;
    assign address       = address_r;
    assign we_L          = we_r;
    assign re_L          = re_r;
    // Only write states drive the bus; reads always follow an IDLE cycle
    assign data          = drive_r ? wdata_r : {DATA_W{1'bz}};

    // Next-state decode; a read waits until any held response is taken
    always_comb begin
        state_s   = state_r;
        pop_s     = 1'b0;
        capture_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (fifo_empty_s) begin
                    state_s = IDLE;
                end else if (head_write_s) begin
                    state_s = WR_SETUP;
                    pop_s   = 1'b1;
                end else if (!rsp_valid_r || bus.rsp_ready) begin
                    state_s = RD_ACCESS;
                    pop_s   = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            WR_SETUP:  state_s = WR_STROBE;
            WR_STROBE: state_s = IDLE;
            RD_ACCESS: begin
                if (wait_cnt_r == 3'd0) begin
                    state_s   = IDLE;
                    capture_s = 1'b1;
                end else begin
                    state_s = RD_ACCESS;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State, registered bus outputs, wait counter and response holding
    always_ff @(posedge clock) begin
        if (!reset_L) begin
            state_r     <= IDLE;
            address_r   <= {ADDR_W{1'b0}};
            wdata_r     <= {DATA_W{1'b0}};
            drive_r     <= 1'b0;
            we_r        <= MEM_NO_WR;
            re_r        <= MEM_NO_RD;
            wait_cnt_r  <= 3'd0;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {DATA_W{1'b0}};
        end else begin
            state_r <= state_s;
            if (pop_s) begin
                address_r  <= head_addr_s;
                wdata_r    <= head_wdata_s;
                wait_cnt_r <= WAIT_CNT_INIT;
            end else if ((state_r == RD_ACCESS) && (wait_cnt_r != 3'd0)) begin
                wait_cnt_r <= wait_cnt_r - 3'd1;
            end
            we_r    <= (state_s == WR_STROBE) ? MEM_WR : MEM_NO_WR;
            re_r    <= (state_s == RD_ACCESS) ? MEM_RD : MEM_NO_RD;
            drive_r <= (state_s == WR_SETUP) || (state_s == WR_STROBE);
            if (capture_s) begin
                rsp_valid_r <= 1'b1;
                rsp_rdata_r <= data;
            end else if (rsp_take_s) begin
                rsp_valid_r <= 1'b0;
            end
        end
    end

`ifdef MEM_BUS_MASTER_STATS_EN
    logic [15:0] rd_count_r;
    logic [15:0] wr_count_r;

    // Saturating completed-transaction counters
    always_ff @(posedge clock) begin
        if (!reset_L) begin
            rd_count_r <= 16'h0000;
            wr_count_r <= 16'h0000;
        end else begin
            if (capture_s) begin
                rd_count_r <= sat_inc16(rd_count_r);
            end
            if (state_r == WR_STROBE) begin
                wr_count_r <= sat_inc16(wr_count_r);
            end
        end
    end

    assign rd_count = rd_count_r;
    assign wr_count = wr_count_r;
`else
    assign rd_count = 16'h0000;
    assign wr_count = 16'h0000;
`endif
endmodule

// File: tb/tb_mem_bus_master.sv
// Self-checking bench for mem_bus_master: directed timing checks plus a
// randomized phase scored against a word-addressed memory model.
module tb_mem_bus_master;
    import mem_bus_master_pkg::*;

    localparam int WS = 2;

    logic          clock = 1'b0;
    logic          reset_L;
    logic [15:0]   address;
    wr_cond_code_t we_L;
    rd_cond_code_t re_L;
    wire  [15:0]   data;
    logic [15:0]   rd_count;
    logic [15:0]   wr_count;

    int checks = 0;
    int errors = 0;
    bit rand_rdy = 1'b0;

    logic [15:0] chip_mem [0:65535];
    logic [15:0] ref_mem  [0:65535];
    logic [15:0] exp_q [$];
    logic [15:0] got_q [$];

    mem_bus_master_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    mem_bus_master #(
        .ADDR_W      (16),
        .DATA_W      (16),
        .WAIT_STATES (WS),
        .QDEPTH      (2)
    ) dut (
        .clock    (clock),
        .reset_L  (reset_L),
        .bus      (bus.slave),
        .address  (address),
        .we_L     (we_L),
        .re_L     (re_L),
        .data     (data),
        .rd_count (rd_count),
        .wr_count (wr_count)
    );

    always #5 clock = ~clock;

    // Memory chip: drives data while re_L is active, writes at the closing edge of a strobe
    assign data = (re_L == MEM_RD) ? chip_mem[address] : 16'hzzzz;
    always @(posedge clock) begin
        if (we_L == MEM_WR) chip_mem[address] = data;
    end

    // Reference model: requests execute in order, so reads see all earlier writes
    always @(posedge clock) begin
        if (reset_L && bus.req_valid && bus.req_ready) begin
            if (bus.req_write) ref_mem[bus.req_addr] = bus.req_wdata;
            else exp_q.push_back(ref_mem[bus.req_addr]);
        end
    end

    // Collect every accepted response
    always @(posedge clock) begin
        if (reset_L && bus.rsp_valid && bus.rsp_ready) got_q.push_back(bus.rsp_rdata);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        if (rand_rdy) bus.rsp_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic push(input logic w, input logic [15:0] a, input logic [15:0] d);
        bit done = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        for (int i = 0; i < 200 && !done; i++) begin
            if (bus.req_ready) done = 1'b1;
            tick();
        end
        bus.req_valid = 1'b0;
        check("push_accepted", 32'(done), 32'd1);
    endtask

    task automatic wait_rsp(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (bus.rsp_valid) seen = 1'b1;
            else tick();
        end
        check({tag, "_rsp_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic sb_check(input string tag);
        logic [15:0] g;
        logic [15:0] e;
        check({tag, "_rsp_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            check({tag, "_rsp_data"}, 32'(g), 32'(e));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    // Single read with rsp_ready held high: re_L for WS+1 cycles, valid WS+2 cycles after head
    task automatic read_timing(input string tag, input logic [15:0] a, input logic [15:0] exp);
        push(1'b0, a, 16'h0000);
        check({tag, "_idle_re"}, 32'(re_L), 32'(MEM_NO_RD));
        for (int k = 0; k <= WS; k++) begin
            tick();
            check({tag, "_re_active"}, 32'(re_L), 32'(MEM_RD));
            check({tag, "_addr"}, 32'(address), 32'(a));
            check({tag, "_early_valid"}, 32'(bus.rsp_valid), 32'd0);
        end
        tick();
        check({tag, "_re_done"}, 32'(re_L), 32'(MEM_NO_RD));
        check({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
        check({tag, "_rdata"}, 32'(bus.rsp_rdata), 32'(exp));
        tick();
        check({tag, "_valid_1cyc"}, 32'(bus.rsp_valid), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_address"}, 32'(address), 32'd0);
        check({tag, "_we"}, 32'(we_L), 32'(MEM_NO_WR));
        check({tag, "_re"}, 32'(re_L), 32'(MEM_NO_RD));
        check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, "_rsp_rdata"}, 32'(bus.rsp_rdata), 32'd0);
        check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
        check({tag, "_rd_count"}, 32'(rd_count), 32'd0);
        check({tag, "_wr_count"}, 32'(wr_count), 32'd0);
    endtask

    initial begin
        logic [15:0] saved;
        logic [15:0] a;
        reset_L       = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = 16'h0000;
        bus.req_wdata = 16'h0000;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 65536; i++) begin
            chip_mem[i] = 16'($urandom);
            ref_mem[i]  = chip_mem[i];
        end
        chip_mem[16'h0010] = 16'hBEEF;
        ref_mem[16'h0010]  = 16'hBEEF;

        repeat (3) tick();
        check_reset_values("rst");
        reset_L = 1'b1;
        tick();

        // Write 0x00A5 <- 0x1234: setup, one strobe cycle, then idle
        bus.rsp_ready = 1'b1;
        push(1'b1, 16'h00A5, 16'h1234);
        tick();
        check("t1_setup_addr", 32'(address), 32'h00A5);
        check("t1_setup_we", 32'(we_L), 32'(MEM_NO_WR));
        check("t1_setup_data", 32'(data), 32'h1234);
        tick();
        check("t1_strobe_we", 32'(we_L), 32'(MEM_WR));
        check("t1_strobe_addr", 32'(address), 32'h00A5);
        check("t1_strobe_data", 32'(data), 32'h1234);
        tick();
        check("t1_after_we", 32'(we_L), 32'(MEM_NO_WR));
        check("t1_mem", 32'(chip_mem[16'h00A5]), 32'h1234);
        read_timing("t1_rd", 16'h00A5, 16'h1234);

        // Preloaded read with wait states
        read_timing("t2_rd", 16'h0010, 16'hBEEF);
        sb_check("t12");

        // Two reads with the consumer stalled: first held stable, second not issued
        bus.rsp_ready = 1'b0;
        push(1'b0, 16'h0001, 16'h0000);
        push(1'b0, 16'h0002, 16'h0000);
        wait_rsp("t3_first");
        for (int i = 0; i < 10; i++) begin
            check("t3_hold_valid", 32'(bus.rsp_valid), 32'd1);
            check("t3_hold_rdata", 32'(bus.rsp_rdata), 32'(ref_mem[16'h0001]));
            check("t3_no_issue", 32'(re_L), 32'(MEM_NO_RD));
            tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        wait_rsp("t3_second");
        tick();
        sb_check("t3");

        // Queue fills behind a blocked read; the third request must see req_ready=0
        bus.rsp_ready = 1'b0;
        push(1'b0, 16'h0020, 16'h0000);
        wait_rsp("t4_r0");
        push(1'b0, 16'h0021, 16'h0000);
        push(1'b0, 16'h0022, 16'h0000);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 16'h0023;
        check("t4_full_ready", 32'(bus.req_ready), 32'd0);
        repeat (3) tick();
        check("t4_still_full", 32'(bus.req_ready), 32'd0);
        bus.rsp_ready = 1'b1;
        push(1'b0, 16'h0023, 16'h0000);
        repeat (30) tick();
        sb_check("t4");

        // Top-of-space address, then randomized traffic with random consumer stalls
        push(1'b1, 16'hFFFF, 16'h5A5A);
        push(1'b0, 16'hFFFF, 16'h0000);
        repeat (10) tick();
        check("tb_ffff_mem", 32'(chip_mem[16'hFFFF]), 32'h5A5A);
        rand_rdy = 1'b1;
        for (int i = 0; i < 24; i++) begin
            a = 16'($urandom_range(16'h0030, 16'h0037));
            push(1'($urandom_range(0, 1)), a, 16'($urandom));
        end
        rand_rdy = 1'b0;
        bus.rsp_ready = 1'b1;
        repeat (40) tick();
        sb_check("rand");

        // Reset during the strobe aborts the transaction and flushes the queue
        saved = ref_mem[16'h0100];
        push(1'b1, 16'h00FF, 16'hAAAA);
        push(1'b1, 16'h0100, 16'h5555);
        tick();
        check("t5_strobe_we", 32'(we_L), 32'(MEM_WR));
        check("t5_strobe_addr", 32'(address), 32'h00FF);
        reset_L = 1'b0;
        tick();
        check_reset_values("t5_rst");
        reset_L = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t5_no_write", 32'(we_L), 32'(MEM_NO_WR));
        end
        check("t5_dropped_mem", 32'(chip_mem[16'h0100]), 32'(saved));
        ref_mem[16'h0100] = saved;
        got_q.delete();
        exp_q.delete();

        // Statistics: three writes and two reads since the last reset
        push(1'b1, 16'h0040, 16'h1111);
        push(1'b1, 16'h0041, 16'h2222);
        push(1'b1, 16'h0042, 16'h3333);
        push(1'b0, 16'h0040, 16'h0000);
        push(1'b0, 16'h0041, 16'h0000);
        repeat (20) tick();
`ifdef MEM_BUS_MASTER_STATS_EN
        check("t6_wr_count", 32'(wr_count), 32'd3);
        check("t6_rd_count", 32'(rd_count), 32'd2);
`else
        check("t6_wr_count", 32'(wr_count), 32'd0);
        check("t6_rd_count", 32'(rd_count), 32'd0);
`endif
        sb_check("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
